// File: rtl/reg_commit_arbiter_if.sv
// rtl/reg_commit_arbiter_if.sv - commit, rollback and register-file write bus of the commit arbiter
interface reg_commit_arbiter_if #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
);
  logic              c0_valid_in;
  logic [REG_W-1:0]  c0_rd_in;
  logic [DATA_W-1:0] c0_v_in;
  logic [ROB_W-1:0]  c0_q_in;
  logic              c1_valid_in;
  logic [REG_W-1:0]  c1_rd_in;
  logic [DATA_W-1:0] c1_v_in;
  logic [ROB_W-1:0]  c1_q_in;
  logic              commit_ready_out;
  logic              rollback_req_in;
  logic [REG_W-1:0]  rd_to_reg;
  logic [DATA_W-1:0] V_to_reg;
  logic [ROB_W-1:0]  Q_to_reg;
  logic              commit_flag_to_reg;
  logic              rollback_flag_to_reg;
  logic              busy_out;

  modport master (
    output c0_valid_in, c0_rd_in, c0_v_in, c0_q_in,
    output c1_valid_in, c1_rd_in, c1_v_in, c1_q_in,
    output rollback_req_in,
    input  commit_ready_out, rd_to_reg, V_to_reg, Q_to_reg,
    input  commit_flag_to_reg, rollback_flag_to_reg, busy_out
  );

  modport slave (
    input  c0_valid_in, c0_rd_in, c0_v_in, c0_q_in,
    input  c1_valid_in, c1_rd_in, c1_v_in, c1_q_in,
    input  rollback_req_in,
    output commit_ready_out, rd_to_reg, V_to_reg, Q_to_reg,
    output commit_flag_to_reg, rollback_flag_to_reg, busy_out
  );
endinterface

// File: rtl/reg_commit_arbiter.sv
// rtl/reg_commit_arbiter.sv - dual-commit to single-write-port arbiter with ordered rollback
module reg_commit_arbiter #(
  parameter int DEPTH  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  reg_commit_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DUAL_LIMIT = CNT_W'(DEPTH - 2);

  typedef enum logic [1:0] {RUN, RB_WAIT, RB_PULSE} state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] v;
    logic [ROB_W-1:0]  q;
  } entry_t;

  state_t state, state_next;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  entry_t           out_q;
  logic             commit_flag_q;

  entry_t           c0_ent, c1_ent, head;
  logic             fifo_empty, commit_ready, accept, push0, push1, pop;
  logic [CNT_W-1:0] n_push;

  assign c0_ent = '{rd: bus.c0_rd_in, v: bus.c0_v_in, q: bus.c0_q_in};
  assign c1_ent = '{rd: bus.c1_rd_in, v: bus.c1_v_in, q: bus.c1_q_in};

  assign fifo_empty   = (count == '0);
  assign commit_ready = (state == RUN) && (count <= DUAL_LIMIT);
  assign accept       = rdy_in && commit_ready;
  assign push0        = accept && bus.c0_valid_in;
  assign push1        = accept && bus.c1_valid_in;
  assign n_push       = CNT_W'(push0) + CNT_W'(push1);
  // An empty FIFO forwards the oldest incoming entry so it reaches the outputs one cycle later.
  assign pop          = rdy_in && (!fifo_empty || push0 || push1);

  always_comb begin
    head = c1_ent;
    if (!fifo_empty) begin
      head = mem[rd_ptr];
    end else if (push0) begin
      head = c0_ent;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push0) begin
      mem[wr_ptr] <= c0_ent;
    end
    if (push1) begin
      mem[wr_ptr + PTR_W'(push0)] <= c1_ent;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out_q         <= '0;
      commit_flag_q <= 1'b0;
    end else if (rdy_in) begin
      wr_ptr        <= wr_ptr + PTR_W'(n_push);
      count         <= count + n_push - CNT_W'(pop);
      commit_flag_q <= pop;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        out_q  <= head;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Rollback requests while already waiting or pulsing fold into the pending one.
  always_comb begin
    state_next = state;
    if (rdy_in) begin
      case (state)
        RUN:      if (bus.rollback_req_in) state_next = RB_WAIT;
        RB_WAIT:  if (fifo_empty && !pop) state_next = RB_PULSE;
        RB_PULSE: state_next = RUN;
        default:  state_next = RUN;
      endcase
    end
  end

  assign bus.commit_ready_out     = commit_ready;
  assign bus.rd_to_reg            = out_q.rd;
  assign bus.V_to_reg             = out_q.v;
  assign bus.Q_to_reg             = out_q.q;
  assign bus.commit_flag_to_reg   = commit_flag_q;
  assign bus.rollback_flag_to_reg = (state == RB_PULSE);
  assign bus.busy_out             = !fifo_empty || commit_flag_q || (state != RUN);
endmodule
